// File: rtl/key_receive.sv
// rtl/key_receive.sv - beep-coded key frame receiver with ready/valid key hand-off
module key_receive #(
   parameter int SYMBOL_LEN = 32,
   parameter int BEEP_LEN   = 16,
   parameter int GAP_LEN    = 8,
   parameter int KEY_BITS   = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ant_in,
   output logic [KEY_BITS-1:0] key_out,
   output logic                key_valid,
   input  logic                key_ready,
   output logic                frame_err,
   output logic                busy
);

   localparam int SEC_LEN = SYMBOL_LEN - BEEP_LEN - GAP_LEN;
   localparam int PH_W    = $clog2(SYMBOL_LEN);
   localparam int BC_W    = $clog2(BEEP_LEN + 1);
   localparam int SC_W    = $clog2(SEC_LEN + 1);
   localparam int BT_W    = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SYMBOL_LEN - 1);
   localparam logic [BT_W-1:0] BIT_LAST = BT_W'(KEY_BITS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic                s1, s, s_d;
   logic [1:0]          state;
   logic [PH_W-1:0]     phase;
   logic [BC_W-1:0]     beep_cnt;
   logic [SC_W-1:0]     sec_cnt;
   logic [BT_W-1:0]     bit_cnt;
   logic [KEY_BITS-1:0] shift_reg;

   logic                in_beep, in_sec, beep_err, bit_val;
   logic [BC_W-1:0]     beep_total;
   logic [SC_W-1:0]     sec_total;
   logic [KEY_BITS-1:0] shift_next;

   assign busy = (state == ST_RECV);

   // Two-flop synchronizer on the antenna line plus a delayed copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1  <= 1'b0;
         s   <= 1'b0;
         s_d <= 1'b0;
      end else begin
         s1  <= ant_in;
         s   <= s1;
         s_d <= s;
      end
   end

   // Window membership and end-of-symbol decision, including the current sample
   always_comb begin
      in_beep    = (32'(phase) < BEEP_LEN);
      in_sec     = (32'(phase) >= (BEEP_LEN + GAP_LEN));
      beep_total = beep_cnt + BC_W'(in_beep && s);
      sec_total  = sec_cnt + SC_W'(in_sec && s);
      beep_err   = ((32'(beep_total) * 4) < (3 * BEEP_LEN));
      bit_val    = ((32'(sec_total) * 2) > SEC_LEN);
      shift_next = (shift_reg << 1) | KEY_BITS'(bit_val);
   end

   // Receive FSM: symbol timing, bit assembly, frame hand-off and error recovery
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         beep_cnt  <= '0;
         sec_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               // The edge cycle itself is phase 0 and already counts as one beep sample
               if (s && !s_d) begin
                  state     <= ST_RECV;
                  phase     <= PH_W'(1);
                  beep_cnt  <= BC_W'(1);
                  sec_cnt   <= '0;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
               end
            end
            ST_RECV: begin
               if (phase == PH_LAST) begin
                  phase    <= '0;
                  beep_cnt <= '0;
                  sec_cnt  <= '0;
                  if (beep_err) begin
                     // Bad symbol drops the partial frame; the last good key stays put
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end else begin
                     shift_reg <= shift_next;
                     if (bit_cnt == BIT_LAST) begin
                        key_out   <= shift_next;
                        key_valid <= 1'b1;
                        state     <= ST_DONE;
                        bit_cnt   <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + BT_W'(1);
                     end
                  end
               end else begin
                  phase    <= phase + PH_W'(1);
                  beep_cnt <= beep_total;
                  sec_cnt  <= sec_total;
               end
            end
            ST_DONE: begin
               if (key_valid && key_ready) begin
                  key_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_receive.sv
// tb/tb_key_receive.sv - scoreboard bench for key_receive
module tb_key_receive;

   localparam logic [255:0] KEY_A5 = {32{8'hA5}};
   localparam logic [255:0] KEY_C  = {4{64'h0123456789ABCDEF}};
   localparam logic [255:0] KEY_D  = ~KEY_C;

   logic         clk = 1'b0;
   logic         reset;
   logic         ant_in;
   logic [255:0] key_out;
   logic         key_valid;
   logic         key_ready;
   logic         frame_err;
   logic         busy;

   int           checks = 0;
   int           errors = 0;
   int           fe_count = 0;
   logic         prev_kv = 1'b0;
   logic         prev_fe = 1'b0;
   logic [255:0] exp_key;
   logic [255:0] exp_q[$];
   logic [255:0] key_r;
   int           hold_drop;

   key_receive dut (
      .clk      (clk),
      .reset    (reset),
      .ant_in   (ant_in),
      .key_out  (key_out),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // mode 0 clean, 1 noisy, 2 beep dropout at phases 4-11, 3 beep cut short after phase 7
   function automatic logic level(input logic b, input int mode, input int p);
      logic v;
      v = (p < 16) || (b && p >= 24);
      if (mode == 1) begin
         if (b && (p == 25 || p == 27 || p == 29)) v = 1'b0;
         if (p == 17 || p == 19 || p == 21) v = 1'b1;
      end
      if (mode == 2 && p >= 4 && p <= 11) v = 1'b0;
      if (mode == 3 && p >= 8 && p < 16) v = 1'b0;
      return v;
   endfunction

   task automatic send_frame(input logic [255:0] key, input int noisy, input int bad_idx,
                             input int bad_mode, input int count);
      int mode;
      for (int i = 0; i < count; i++) begin
         mode = (i == bad_idx) ? bad_mode : noisy;
         for (int p = 0; p < 32; p++) begin
            @(negedge clk);
            ant_in = level(key[255 - i], mode, p);
         end
      end
   endtask

   task automatic expect_valid(input string tag);
      @(negedge clk);
      ant_in = 1'b0;
      @(negedge clk);
      check({tag, "_kv_early"}, 256'(key_valid), 256'(0));
      @(negedge clk);
      check({tag, "_kv_lat"}, 256'(key_valid), 256'(1));
      check({tag, "_busy"}, 256'(busy), 256'(0));
   endtask

   task automatic expect_err(input string tag, input logic [255:0] prior);
      @(negedge clk);
      ant_in = 1'b0;
      @(negedge clk);
      check({tag, "_fe_early"}, 256'(frame_err), 256'(0));
      @(negedge clk);
      check({tag, "_fe"}, 256'(frame_err), 256'(1));
      check({tag, "_busy"}, 256'(busy), 256'(0));
      check({tag, "_kv"}, 256'(key_valid), 256'(0));
      check({tag, "_key"}, key_out, prior);
   endtask

   task automatic ack(input string tag);
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      check({tag, "_ack_kv"}, 256'(key_valid), 256'(0));
   endtask

   // Scoreboard: each rising key_valid consumes the oldest expected key
   always @(negedge clk) begin
      if (key_valid && !prev_kv) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 256'(1), 256'(0));
         end else begin
            exp_key = exp_q.pop_front();
            check("sb_key", key_out, exp_key);
         end
      end
      if (prev_fe) check("fe_width", 256'(frame_err), 256'(0));
      if (frame_err && !prev_fe) fe_count++;
      prev_kv = key_valid;
      prev_fe = frame_err;
   end

   initial begin
      reset     = 1'b1;
      ant_in    = 1'b0;
      key_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_key", key_out, 256'(0));
      check("rst_kv", 256'(key_valid), 256'(0));
      check("rst_fe", 256'(frame_err), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Clean A5 frame, then a long hold before acknowledging
      exp_q.push_back(KEY_A5);
      send_frame(KEY_A5, 0, -1, 0, 256);
      expect_valid("a5");
      hold_drop = 0;
      repeat (100) begin
         @(negedge clk);
         if (!key_valid) hold_drop++;
      end
      check("hold_kv", 256'(hold_drop), 256'(0));
      ack("a5");
      check("ack_busy", 256'(busy), 256'(0));
      check("ack_key", key_out, KEY_A5);
      repeat (10) @(negedge clk);

      // Beep dropout in symbol 10
      send_frame(KEY_C, 0, 10, 2, 11);
      expect_err("dropout", KEY_A5);
      repeat (20) @(negedge clk);

      // Noisy random key
      key_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(key_r);
      send_frame(key_r, 1, -1, 0, 256);
      expect_valid("noisy");
      ack("noisy");
      repeat (10) @(negedge clk);

      // Reset in the middle of bit 130, then a full fresh frame
      send_frame(KEY_D, 0, -1, 0, 130);
      repeat (6) begin
         @(negedge clk);
         ant_in = 1'b1;
      end
      check("mid_busy", 256'(busy), 256'(1));
      reset = 1'b1;
      @(negedge clk);
      check("mrst_key", key_out, 256'(0));
      check("mrst_busy", 256'(busy), 256'(0));
      ant_in = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      exp_q.push_back(KEY_C);
      send_frame(KEY_C, 0, -1, 0, 256);
      expect_valid("c");
      ack("c");
      repeat (10) @(negedge clk);

      // Bad beep on the final symbol must not publish the frame
      send_frame(KEY_D, 0, 255, 3, 256);
      expect_err("last_bad", KEY_C);
      repeat (20) @(negedge clk);
      check("last_kv", 256'(key_valid), 256'(0));
      check("last_key", key_out, KEY_C);

      check("fe_count", 256'(fe_count), 256'(2));
      check("sb_left", 256'(exp_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_receive.md
KEY_RECEIVE -- requirements
Module: key_receive

Interface
REQ-001 The block SHALL have parameter SYMBOL_LEN, default 32, cycles per symbol.
REQ-002 The block SHALL have parameter BEEP_LEN, default 16, cycles of the leading beep (phases 0..BEEP_LEN-1).
REQ-003 The block SHALL have parameter GAP_LEN, default 8, short-pause length; the '1' second-beep window is phases BEEP_LEN+GAP_LEN..SYMBOL_LEN-1 (default 24..31).
REQ-004 The block SHALL have parameter KEY_BITS, default 256, bits per frame.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ant_in  input  1  asynchronous antenna/beep line, high = beep.
REQ-008 key_out  output  KEY_BITS  last complete received key, first-received bit in MSB.
REQ-009 key_valid  output  1  high while key_out holds an unacknowledged frame.
REQ-010 key_ready  input  1  consumer acknowledge for key_valid.
REQ-011 frame_err  output  1  one-cycle pulse on symbol decode failure.
REQ-012 busy  output  1  high in RECV state.

Function
REQ-013 ant_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value s, plus a 1-cycle delayed copy s_d.
REQ-014 The FSM SHALL have states IDLE, RECV, DONE.
REQ-015 IDLE: on s=1 and s_d=0, the block SHALL enter RECV; that cycle is phase 0, counted as one high sample; bit counter = 0.
REQ-016 RECV: the phase counter SHALL increment each cycle and wrap SYMBOL_LEN-1 -> 0; symbols are back-to-back with no re-alignment.
REQ-017 Per symbol, the block SHALL count high samples in the beep window (phases 0..BEEP_LEN-1) and in the second-beep window.
REQ-018 At phase SYMBOL_LEN-1, a beep-window count < 3/4*BEEP_LEN (default 12) SHALL be a symbol error.
REQ-019 Otherwise the decoded bit SHALL be 1 if the second-beep count > half the window length (default >= 5 of 8), else 0.
REQ-020 Samples in phases BEEP_LEN..BEEP_LEN+GAP_LEN-1 SHALL be ignored.
REQ-021 Decoded bits SHALL shift into an internal KEY_BITS register at its LSB, so the first bit ends in the MSB.
REQ-022 On the KEY_BITS-th good symbol, key_out SHALL load the full shift register, key_valid SHALL be set the next cycle, and the state SHALL become DONE.
REQ-023 key_out SHALL change only on frame completion; partial frames SHALL never be visible.
REQ-024 A symbol error SHALL pulse frame_err for one cycle, discard the partial frame, clear the bit counter, and return to IDLE; key_out and key_valid SHALL be unaffected.
REQ-025 A symbol error on the final symbol SHALL take precedence: no load, no key_valid.
REQ-026 DONE: ant_in SHALL be ignored; when key_valid and key_ready are both high, key_valid SHALL clear and the state SHALL return to IDLE in the same edge.
REQ-027 key_ready while key_valid=0 SHALL have no effect.
REQ-028 After returning to IDLE, the next rising edge on s SHALL start a new frame, including trailing all-zero symbols from the sender.
REQ-029 Decode latency from the ant_in edge of phase 0 to capture SHALL be 2 cycles (synchronizer).
REQ-030 Counter widths SHALL be sized by $clog2 of their parameter ranges and SHALL never overflow.

Reset
REQ-031 Reset SHALL asynchronously force: state IDLE, synchronizer flops and s_d = 0, phase, sample and bit counters = 0, shift register = 0, key_out = 0, key_valid = 0, frame_err = 0, busy = 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after release, decoding SHALL restart only on a new rising edge.

Verification
REQ-033 Send 256 symbols encoding 256'hA5A5...A5 (0: high 0-15, low 16-31; 1: also high 24-31) -> key_valid rises 1 cycle after the last symbol's phase 31, key_out = 256'hA5A5...A5, frame_err never pulses.
REQ-034 Hold key_ready=0 for 100 cycles after key_valid, then pulse it for 1 cycle -> key_valid stays high throughout the hold, clears on the ack edge, and busy=0.
REQ-035 In symbol 10, force ant_in low for phases 4-11 -> frame_err one-cycle pulse at that symbol's end, state IDLE, key_out unchanged from the previous frame.
REQ-036 Flip 3 samples in the second-beep window of every '1' and 3 samples in the gap region -> decoded key still exact.
REQ-037 Assert reset at bit 130 and release, then send a full frame of 256'h0123...CDEF -> key_out = 256'h0123...CDEF, with no residue from the aborted frame.
REQ-038 Run a full frame whose last symbol has a bad beep window -> frame_err pulses, key_valid stays 0, and key_out keeps its prior value.
